waveform_to_pipe_bram: RTL

- Capture-side counterpart of the pipe-in waveform generator.
- Each `sample_valid` strobe (one per `sim_clk` tick, synchronised upstream) stores one 32-bit IEEE float: muscle force, Ia rate or elbow position.
- Samples are split into 16-bit words and buffered in a BRAM FIFO.
- The FIFO is drained by okBTPipeOut (addr 0xA0) using the `ep_read`/`ep_ready` block-transfer handshake.

---
 rtl/waveform_to_pipe_bram.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/waveform_to_pipe_bram.sv
// -----------------------------------------------------------------------------
// waveform_to_pipe_bram
//
// Capture-side buffer for the waveform pipe. Each accepted 32-bit float sample
// is split into 16-bit words (LO then HI) and written into a BRAM FIFO. The
// FIFO is drained by okBTPipeOut through the ep_read / ep_ready block-transfer
// handshake.
//
// Optional feature: define WAVE_PIPEOUT_TIMESTAMP_EN to prefix every stored
// sample with a 16-bit tick stamp (word order TS, LO, HI). The stamp counts
// every sample_valid strobe, including dropped ones, so the host can see gaps.
//
// Ports:
//   clk          ti_clk, all logic is synchronous to it
//   reset_n      asynchronous active-low reset
//   clear        synchronous flush; wins over a simultaneous sample or read
//   sample_valid single-cycle strobe qualifying sample_data
//   sample_data  32-bit float sample
//   pipe_read    ep_read from okBTPipeOut; pops the head word
//   pipe_data    ep_datain; popped word, valid the cycle after pipe_read
//   pipe_ready   ep_ready; registered (word_count >= BLOCK_WORDS)
//   word_count   FIFO occupancy in words
//   overflow     sticky, set when any sample is dropped
//   drop_count   saturating count of dropped samples
// -----------------------------------------------------------------------------
module waveform_to_pipe_bram #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [31:0]           sample_data,
  input  logic                  pipe_read,
  output logic [15:0]           pipe_data,
  output logic                  pipe_ready,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] BLOCK_C = (DEPTH_LOG2+1)'(BLOCK_WORDS);
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
  localparam logic [DEPTH_LOG2:0] WPS = (DEPTH_LOG2+1)'(3);
`else
  localparam logic [DEPTH_LOG2:0] WPS = (DEPTH_LOG2+1)'(2);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
    W_TS = 2'd1,
`endif
    W_LO = 2'd2,
    W_HI = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [15:0]             pipe_data_q, pipe_data_d;
  logic                    pipe_ready_q, pipe_ready_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;

  logic [15:0]             mem_q [DEPTH];
  logic [31:0]             sample_q;
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
  logic [15:0]             tick_q, tick_d;
  logic [15:0]             ts_q;
`endif

  logic [DEPTH_LOG2:0]     free_words;
  logic                    accept, drop, pop;
  logic                    wr_en;
  logic [15:0]             wr_word;

  // Space is reserved for the whole sample at acceptance, so the write states
  // never find the FIFO full and a partial sample can never be stored.
  assign free_words = DEPTH_C - count_q;
  assign accept     = sample_valid && (state_q == IDLE) && (free_words >= WPS);
  assign drop       = sample_valid && !accept;
  assign pop        = pipe_read && (count_q != '0);

  // Write FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Write FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
      IDLE:    if (accept) state_d = W_TS;
      W_TS:    state_d = W_LO;
`else
      IDLE:    if (accept) state_d = W_LO;
`endif
      W_LO:    state_d = W_HI;
      W_HI:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Write FSM: outputs (one word per write state)
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    case (state_q)
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
      W_TS: begin wr_en = 1'b1; wr_word = ts_q;             end
`endif
      W_LO: begin wr_en = 1'b1; wr_word = sample_q[15:0];  end
      W_HI: begin wr_en = 1'b1; wr_word = sample_q[31:16]; end
      default: ;
    endcase
  end

  // Pointers, occupancy, read data and status
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pipe_data_d  = pipe_data_q;
    pipe_ready_d = (count_q >= BLOCK_C);
    overflow_d   = overflow_q;
    drop_d       = drop_q;
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
    tick_d       = sample_valid ? tick_q + 16'd1 : tick_q;
`endif
    if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (wr_en && !pop)      count_d = count_q + (DEPTH_LOG2+1)'(1);
    else if (!wr_en && pop) count_d = count_q - (DEPTH_LOG2+1)'(1);
    // A read on an empty FIFO returns zero rather than stale data.
    if (pipe_read) pipe_data_d = pop ? mem_q[rd_ptr_q] : 16'h0000;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
    end
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pipe_data_d  = '0;
      pipe_ready_d = 1'b0;
      overflow_d   = 1'b0;
      drop_d       = '0;
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
      tick_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pipe_data_q  <= '0;
      pipe_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
      tick_q       <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pipe_data_q  <= pipe_data_d;
      pipe_ready_q <= pipe_ready_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
      tick_q       <= tick_d;
`endif
    end
  end

  // Sample latch and BRAM array carry no reset; the FSM alone decides whether
  // their contents are ever used.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_q <= sample_data;
`ifdef WAVE_PIPEOUT_TIMESTAMP_EN
      ts_q     <= tick_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign pipe_data  = pipe_data_q;
  assign pipe_ready = pipe_ready_q;
  assign word_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule
